// File: rtl/fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fwd_hazard_unit
//  Brief    : Operand forwarding select (youngest writer wins, registered
//             one-hot per source) and load-use interlock for the RV32I pipe.
//             Optional interlock enabled by defining FWD_LDINTLK_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module fwd_hazard_unit #(
    parameter int NSRC  = 2,
    parameter int NSTG  = 3,
    parameter int RADR  = 5,
    parameter int LDLAT = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NSRC*RADR-1:0]        src_id_i,
    input  logic [NSRC-1:0]             src_valid_i,
    input  logic [NSTG*RADR-1:0]        rd_adr_i,
    input  logic [NSTG-1:0]             wbk_rd_i,
    input  logic [NSTG-1:0]             cmd_ld_i,
    input  logic                        stall_i,
    input  logic                        rst_pipe_i,
    output logic [NSRC*(NSTG+1)-1:0]    sel_ex_o,
    output logic                        ld_stall_o
);

    localparam int C_SELW = NSTG + 1;

    logic [NSRC*C_SELW-1:0] w_sel_new;
    logic [NSRC*C_SELW-1:0] sel_ex_q;
    logic [NSRC*C_SELW-1:0] sel_ex_d;
    logic                   w_intlk;

    for (genvar s = 0; s < NSRC; s++) begin : g_src
        logic [RADR-1:0]   w_id;
        logic [NSTG-1:0]   w_hit;
        logic [C_SELW-1:0] w_sel;

        assign w_id = src_id_i[s*RADR +: RADR];

        for (genvar j = 0; j < NSTG; j++) begin : g_stg
            assign w_hit[j] = src_valid_i[s] & wbk_rd_i[j]
                            & (w_id == rd_adr_i[j*RADR +: RADR])
                            & (w_id != '0);
        end

        // Scan oldest to youngest so the youngest hit overwrites older ones.
        always_comb begin
            w_sel         = '0;
            w_sel[NSTG]   = 1'b1;
            for (int j = NSTG - 1; j >= 0; j--) begin
                if (w_hit[j]) begin
                    w_sel    = '0;
                    w_sel[j] = 1'b1;
                end
            end
        end

        assign w_sel_new[s*C_SELW +: C_SELW] = w_sel;
    end

`ifdef FWD_LDINTLK_EN
    localparam int C_CW = $clog2(LDLAT) + 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    state_e          state_q;
    state_e          state_d;
    logic [C_CW-1:0] cnt_q;
    logic [C_CW-1:0] cnt_d;
    logic            w_hz;
    logic [C_CW-1:0] w_ld_val;

    // A load wins only if its stage is still inside the non-forwardable window;
    // the youngest such stage sets how long the interlock must last.
    always_comb begin
        w_hz     = 1'b0;
        w_ld_val = '0;
        for (int j = NSTG - 1; j >= 0; j--) begin
            for (int s = 0; s < NSRC; s++) begin
                if ((j < LDLAT) && cmd_ld_i[j] && w_sel_new[s*C_SELW + j]) begin
                    w_hz     = 1'b1;
                    w_ld_val = C_CW'(LDLAT - 1 - j);
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        w_intlk = 1'b0;
        if (rst_pipe_i) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_hz) begin
                        w_intlk = 1'b1;
                        if (!stall_i) begin
                            cnt_d   = w_ld_val;
                            state_d = (w_ld_val != '0) ? ST_HOLD : ST_IDLE;
                        end
                    end
                end
                ST_HOLD: begin
                    w_intlk = 1'b1;
                    if (!stall_i) begin
                        cnt_d = cnt_q - C_CW'(1);
                        if (cnt_q == C_CW'(1)) begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        if (rst) begin
            w_intlk = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
`else
    localparam int c_ldlat_unused = LDLAT;
    logic          w_cmd_ld_unused;

    assign w_cmd_ld_unused = ^cmd_ld_i;
    assign w_intlk         = 1'b0;
`endif

    // An interlocked cycle pushes a bubble (all-zero select) into EX.
    always_comb begin
        sel_ex_d = sel_ex_q;
        if (rst_pipe_i) begin
            sel_ex_d = '0;
        end else if (!stall_i) begin
            sel_ex_d = w_intlk ? '0 : w_sel_new;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_ex_q <= '0;
        end else begin
            sel_ex_q <= sel_ex_d;
        end
    end

    assign sel_ex_o   = sel_ex_q;
    assign ld_stall_o = w_intlk;

endmodule
`default_nettype wire

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised operand forwarding and load-use interlock unit for the RV32I pipeline. It compares each ID-stage source register against the destination of every younger-to-older downstream stage and picks the youngest match. The result is registered as a one-hot bypass select for the EX stage. It also detects load-use hazards and drives a multi-cycle interlock request to the pipeline controller.

## Interface
- NSRC, 2: number of source operands per instruction (rs1, rs2, ...).
- NSTG, 3: number of compared stages; index 0 = EX (youngest), NSTG-1 = oldest (WB).
- RADR, 5: register address width.
- LDLAT, 1: number of stages, from index 0, whose load result is not yet forwardable. Range 1..NSTG.
- clk  in  1  pipeline clock.
- rst  in  1  synchronous active-high reset.
- src_id  in  NSRC*RADR  source register ids; source s occupies bits [s*RADR +: RADR].
- src_valid  in  NSRC  source s is read by the ID instruction.
- rd_adr  in  NSTG*RADR  destination id per stage j.
- wbk_rd  in  NSTG  stage j writes back rd.
- cmd_ld  in  NSTG  stage j holds a load.
- stall  in  1  global pipeline stall; freezes the unit.
- rst_pipe  in  1  pipeline flush.
- sel_ex  out  NSRC*(NSTG+1)  per source, one-hot. Bit j means forward from stage j; bit NSTG means read the register file.
- ld_stall  out  1  load-use interlock request. The ID and IF stages hold, and a bubble is inserted into EX.

## Operation
- Hit(s,j) = src_valid[s] & wbk_rd[j] & (src_id[s]==rd_adr[j]) & (src_id[s]!=0). Register x0 never hits.
- Priority: the lowest j with Hit(s,j) wins, so the youngest writer wins. The selection is one-hot. If no stage hits, bit NSTG is selected.
- Load hazard: the winning stage j satisfies j<LDLAT and cmd_ld[j]. hz = OR of this over all s. k = min such j.
- FSM states:
  - IDLE:
    - If hz & ~stall & ~rst_pipe: ld_stall=1 and cnt<=LDLAT-1-k.
    - If that value is 0, stay in IDLE; otherwise go to HOLD.
    - If there is no hazard, ld_stall=0.
  - HOLD:
    - ld_stall=1 and cnt decrements each unstalled cycle.
    - When cnt==1 and the cycle is unstalled, go to IDLE.
- Capture of sel_ex, on unstalled cycles:
  - When not in interlock (ld_stall=0), sel_ex captures the new selects.
  - When ld_stall=1, sel_ex captures all-zero, which is the bubble.
- stall=1: sel_ex, the FSM state and cnt all hold. ld_stall keeps its current value.
- rst_pipe: sel_ex is set to 0, the FSM goes to IDLE, cnt is set to 0, and ld_stall goes low in that same cycle. This applies even during HOLD and overrides stall.
- rst: same effect as rst_pipe. rst has the highest priority.
- Counter width: clog2(LDLAT)+1 bits. The counter never wraps, because its load value is at most LDLAT-1.

## Timing
- Reset values:
  - sel_ex = 0, all bits including the register-file bit.
  - FSM = IDLE, cnt = 0.
  - ld_stall = 0.
- sel_ex: one-cycle latency. Values computed from the ID inputs at edge N appear at N+1.
- ld_stall: combinational from the inputs while in IDLE, and a registered state while in HOLD. Total assertion is LDLAT-k cycles, excluding stalled cycles.
- If a hazard and rst_pipe occur in the same cycle, rst_pipe wins: ld_stall=0 and no bubble is inserted.
- If stall=1 arrives while the unit is in IDLE with a hazard, ld_stall is still asserted, but the FSM does not advance until stall drops.
- If several stages hit the same source, only the youngest is selected.

## Configuration
- FWD_LDINTLK_EN defined: the load hazard detection, the FSM, the counter and ld_stall are implemented as described above.
- FWD_LDINTLK_EN undefined:
  - No FSM or counter is built, and ld_stall is tied to 0.
  - Load hits select their stage bit like any other hit.
  - The pipeline is then responsible for load data timing.

## Test plan
- Parameters NSRC=2, NSTG=3. src_id[0]=5, rd_adr[0]=5, wbk_rd[0]=1, cmd_ld=0 → next cycle sel_ex source-0 = 4'b0001 and source-1 = 4'b1000.
- src_id[0]=7 with stages 1 and 2 both writing x7 → sel_ex source-0 = 4'b0010. src_id=0 with rd_adr[0]=0 and wbk_rd[0]=1 → 4'b1000.
- LDLAT=1, load x3 in stage 0, src_id[1]=3 → ld_stall=1 for one cycle, and sel_ex=0 the next cycle. With stage inputs advanced, the following cycle gives source-1 = 4'b0010.
- LDLAT=2, load in stage 0 hit → ld_stall high for 2 cycles. Inserting stall=1 for 3 cycles in the middle extends ld_stall to 5 cycles while sel_ex holds.
- In HOLD, rst_pipe=1 → the same cycle gives ld_stall=0, and the next cycle gives sel_ex=0 and the FSM in IDLE. rst=1 with stall=1 → all outputs go to 0 on the next edge.
- FWD_LDINTLK_EN undefined, load x3 in stage 0 → ld_stall stays 0 and the select for that source is 4'b0001.
